// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_LOAD,
        S_CHK,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed word stream -> instruction memory, holds the core until done.
// Optional trailing XOR checksum word when IMEM_LOADER_CHKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

`ifdef IMEM_LOADER_CHKSUM_EN
    localparam loader_state_t DATA_END = S_CHK;
`else
    localparam loader_state_t DATA_END = S_DONE;
`endif

    loader_state_t    state;
    loader_state_t    state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic             handshake;
    logic             len_zero;
    logic             len_over;
    logic             last_word;

`ifdef IMEM_LOADER_CHKSUM_EN
    logic [31:0]      chk_acc;
`endif

    assign handshake = s_valid && s_ready;
    assign len_zero  = (s_data == 32'd0);
    // Full 32-bit compare so set bits above CNT_W also count as oversize.
    assign len_over  = (s_data > 32'(DEPTH));
    assign last_word = (cnt == len - CNT_W'(1));

    // Status outputs are gated by reset so they read inactive for the whole reset window.
    assign s_ready  = reset && ((state == S_LEN) || (state == S_LOAD) || (state == S_CHK));
    assign done     = reset && (state == S_DONE);
    assign err      = reset && (state == S_ERR);
    assign cpu_hold = !done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_LEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LEN: begin
                if (handshake) begin
                    if (len_over) begin
                        state_next = S_ERR;
                    end else if (len_zero) begin
                        state_next = DATA_END;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (handshake && last_word) begin
                    state_next = DATA_END;
                end
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            S_CHK: begin
                if (handshake) begin
                    state_next = (s_data == chk_acc) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            len        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_acc    <= 32'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (handshake && (state == S_LEN)) begin
                len <= s_data[CNT_W-1:0];
                cnt <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                chk_acc <= s_data;
`endif
            end
            if (handshake && (state == S_LOAD)) begin
                imem_we    <= 1'b1;
                imem_addr  <= 32'(cnt) * WORD_BYTES;
                imem_wdata <= s_data;
                cnt        <= cnt + CNT_W'(1);
`ifdef IMEM_LOADER_CHKSUM_EN
                chk_acc <= chk_acc ^ s_data;
`endif
            end
        end
    end

endmodule
